// File: rtl/control_multicycle.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback with memory handshake, illegal-opcode pulse and retire count.
module control_multicycle #(
    parameter int ALUOP_W = 2,
    parameter bit BNE_EN  = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opCode,
    input  logic               mem_ready,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               BranchNe,
    output logic [1:0]         PCSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               illegal_op,
    output logic [3:0]         state,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        BNEEX   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    logic       mem_read_s, mem_write_s, ir_write_s, pc_write_s;
    logic       branch_s, branch_ne_s, reg_write_s;
    logic [1:0] alu_op_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    // Next state, illegal detection and retire qualification.
    always_comb begin
        state_d   = FETCH;
        illegal_d = 1'b0;
        retire    = 1'b0;
        unique case (state_q)
            FETCH:   state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                unique case (opCode)
                    OP_RTYPE:      state_d = RTYPEEX;
                    OP_LW, OP_SW:  state_d = MEMADR;
                    OP_BEQ:        state_d = BEQEX;
                    OP_BNE: begin
                        if (BNE_EN) begin
                            state_d = BNEEX;
                        end else begin
                            state_d   = FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    OP_ADDI:       state_d = ADDIEX;
                    OP_J:          state_d = JEX;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                if (opCode == OP_LW) begin
                    state_d = MEMRD;
                end else if (opCode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
            MEMWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEMWR: begin
                state_d = mem_ready ? FETCH : MEMWR;
                retire  = mem_ready;
            end
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            RTYPEWB, BEQEX, ADDIWB, JEX, BNEEX: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        count_d = retire ? count_q + 1'b1 : count_q;
    end

    // Moore decode of datapath controls.
    always_comb begin
        IorD        = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        branch_s    = 1'b0;
        branch_ne_s = 1'b0;
        reg_write_s = 1'b0;
        PCSrc       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        alu_op_s    = 2'b00;
        unique case (state_q)
            FETCH: begin
                mem_read_s = 1'b1;
                ALUSrcB    = 2'b01;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                IorD       = 1'b1;
                mem_read_s = 1'b1;
            end
            MEMWB: begin
                MemtoReg    = 1'b1;
                reg_write_s = 1'b1;
            end
            MEMWR: begin
                IorD        = 1'b1;
                mem_write_s = 1'b1;
            end
            RTYPEEX: begin
                ALUSrcA  = 1'b1;
                alu_op_s = 2'b10;
            end
            RTYPEWB: begin
                RegDst      = 1'b1;
                reg_write_s = 1'b1;
            end
            BEQEX: begin
                ALUSrcA  = 1'b1;
                alu_op_s = 2'b01;
                PCSrc    = 2'b01;
                branch_s = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:  reg_write_s = 1'b1;
            JEX: begin
                PCSrc      = 2'b10;
                pc_write_s = 1'b1;
            end
            BNEEX: begin
                ALUSrcA     = 1'b1;
                alu_op_s    = 2'b01;
                PCSrc       = 2'b01;
                branch_ne_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are squashed combinationally while reset is held.
    assign MemRead     = mem_read_s  & ~reset;
    assign MemWrite    = mem_write_s & ~reset;
    assign IRWrite     = ir_write_s  & ~reset;
    assign PCWrite     = pc_write_s  & ~reset;
    assign Branch      = branch_s    & ~reset;
    assign BranchNe    = branch_ne_s & ~reset;
    assign RegWrite    = reg_write_s & ~reset;
    assign ALUOp       = ALUOP_W'(alu_op_s);
    assign illegal_op  = illegal_q;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_multicycle.sv
// Directed bench for control_multicycle; a second instance with bne
// disabled covers the illegal-bne path.
module tb_control_multicycle;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opCode;
    logic       mem_ready;

    logic        IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic        Branch, BranchNe, ALUSrcA, RegDst, MemtoReg, RegWrite;
    logic [1:0]  PCSrc, ALUSrcB, ALUOp;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_PCWrite;
    logic        n_Branch, n_BranchNe, n_ALUSrcA, n_RegDst, n_MemtoReg;
    logic        n_RegWrite;
    logic [1:0]  n_PCSrc, n_ALUSrcB, n_ALUOp;
    logic        n_illegal_op;
    logic [3:0]  n_state;
    logic [31:0] n_instr_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cyc0;

    always #5 clk = ~clk;

    control_multicycle #(.ALUOP_W(2), .BNE_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
        .BranchNe(BranchNe), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUOp(ALUOp), .illegal_op(illegal_op),
        .state(state), .instr_count(instr_count)
    );

    control_multicycle #(.ALUOP_W(2), .BNE_EN(1'b0), .CNT_W(32)) dut_nobne (
        .clk(clk), .reset(reset), .opCode(opCode), .mem_ready(mem_ready),
        .IorD(n_IorD), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
        .IRWrite(n_IRWrite), .PCWrite(n_PCWrite), .Branch(n_Branch),
        .BranchNe(n_BranchNe), .PCSrc(n_PCSrc), .ALUSrcA(n_ALUSrcA),
        .ALUSrcB(n_ALUSrcB), .RegDst(n_RegDst), .MemtoReg(n_MemtoReg),
        .RegWrite(n_RegWrite), .ALUOp(n_ALUOp), .illegal_op(n_illegal_op),
        .state(n_state), .instr_count(n_instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        opCode    = 6'b000000;

        // Reset held two cycles
        step();
        chk("rst1_state", 32'(state), 32'd0);
        chk("rst1_memread", 32'(MemRead), 32'd0);
        chk("rst1_irwrite", 32'(IRWrite), 32'd0);
        chk("rst1_pcwrite", 32'(PCWrite), 32'd0);
        step();
        chk("rst2_strobes", 32'({MemRead, MemWrite, IRWrite, PCWrite,
                                 Branch, BranchNe, RegWrite}), 32'd0);
        chk("rst2_count", instr_count, 32'd0);
        chk("rst2_illegal", 32'(illegal_op), 32'd0);
        reset = 1'b0;
        #1;
        chk("fetch_memread", 32'(MemRead), 32'd1);
        chk("fetch_irpc", 32'({IRWrite, PCWrite, ALUSrcB}), 32'b1101);

        // lw: 0,1,2,3,4,0
        opCode = 6'b100011;
        step();
        chk("lw_s1", 32'(state), 32'd1);
        chk("lw_s1_srcb", 32'(ALUSrcB), 32'd3);
        chk("lw_s1_regwrite", 32'(RegWrite), 32'd0);
        step();
        chk("lw_s2", 32'(state), 32'd2);
        chk("lw_s2_src", 32'({ALUSrcA, ALUSrcB, ALUOp}), 32'b11000);
        step();
        chk("lw_s3", 32'(state), 32'd3);
        chk("lw_s3_ctl", 32'({IorD, MemRead, RegWrite}), 32'b110);
        step();
        chk("lw_s4", 32'(state), 32'd4);
        chk("lw_s4_wb", 32'({RegWrite, MemtoReg, RegDst}), 32'b110);
        step();
        chk("lw_done", 32'(state), 32'd0);
        chk("lw_count", instr_count, 32'd1);
        chk("lw_fetch_regwrite", 32'(RegWrite), 32'd0);

        // sw with three mem_ready=0 cycles in MEMWR
        opCode = 6'b101011;
        step();
        chk("sw_s1", 32'(state), 32'd1);
        step();
        chk("sw_s2", 32'(state), 32'd2);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sw_wait_state", 32'(state), 32'd5);
            chk("sw_wait_ctl", 32'({MemWrite, IorD, RegWrite}), 32'b110);
        end
        step();
        chk("sw_last_state", 32'(state), 32'd5);
        chk("sw_last_ctl", 32'({MemWrite, IorD, RegWrite}), 32'b110);
        mem_ready = 1'b1;
        step();
        chk("sw_done", 32'(state), 32'd0);
        chk("sw_count", instr_count, 32'd2);
        chk("sw_fetch_memwrite", 32'(MemWrite), 32'd0);

        // R, beq, addi, j back to back: 14 cycles
        cyc0 = cyc;
        opCode = 6'b000000;
        step();
        step();
        chk("r_s6", 32'(state), 32'd6);
        chk("r_aluop", 32'({ALUSrcA, ALUOp}), 32'b110);
        step();
        chk("r_s7", 32'({RegDst, RegWrite}), 32'b11);
        step();
        chk("r_done", 32'(state), 32'd0);
        opCode = 6'b000100;
        step();
        step();
        chk("beq_s8", 32'(state), 32'd8);
        chk("beq_ctl", 32'({ALUOp, PCSrc, Branch, BranchNe}), 32'b010110);
        step();
        chk("beq_done", 32'(state), 32'd0);
        opCode = 6'b001000;
        step();
        step();
        chk("addi_s9", 32'({state, ALUSrcA, ALUSrcB}), 32'b1001_1_10);
        step();
        chk("addi_s10", 32'({state, RegWrite, RegDst}), 32'b1010_1_0);
        step();
        opCode = 6'b000010;
        step();
        step();
        chk("j_s11", 32'(state), 32'd11);
        chk("j_ctl", 32'({PCWrite, PCSrc}), 32'b110);
        step();
        chk("mix_cycles", 32'(cyc - cyc0), 32'd14);
        chk("mix_state", 32'(state), 32'd0);
        chk("mix_count", instr_count, 32'd6);

        // Illegal opcode pulse
        opCode = 6'b111111;
        step();
        chk("ill_s1", 32'(state), 32'd1);
        chk("ill_pre", 32'(illegal_op), 32'd0);
        step();
        chk("ill_state", 32'(state), 32'd0);
        chk("ill_pulse", 32'(illegal_op), 32'd1);
        chk("ill_count", instr_count, 32'd6);
        opCode = 6'b000101;
        step();
        chk("ill_clear", 32'(illegal_op), 32'd0);
        chk("bne_s1", 32'(state), 32'd1);
        chk("nb_s1", 32'(n_state), 32'd1);
        step();
        chk("bne_s12", 32'(state), 32'd12);
        chk("bne_ctl", 32'({BranchNe, Branch, ALUOp, PCSrc}), 32'b100101);
        chk("nb_state", 32'(n_state), 32'd0);
        chk("nb_pulse", 32'(n_illegal_op), 32'd1);
        step();
        chk("bne_done", 32'(state), 32'd0);
        chk("bne_count", instr_count, 32'd7);
        chk("nb_clear", 32'(n_illegal_op), 32'd0);
        chk("nb_count", n_instr_count, 32'd6);

        // Reset during MEMRD while memory stalls
        opCode = 6'b100011;
        step();
        step();
        chk("rr_s2", 32'(state), 32'd2);
        mem_ready = 1'b0;
        step();
        chk("rr_s3", 32'(state), 32'd3);
        chk("rr_memread", 32'(MemRead), 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_memread_drop", 32'(MemRead), 32'd0);
        step();
        chk("rr_state", 32'(state), 32'd0);
        chk("rr_count", instr_count, 32'd0);
        chk("rr_strobes", 32'({MemRead, IRWrite, PCWrite}), 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        step();
        chk("rr_resume", 32'(state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_multicycle.md
Name: control_multicycle

Overview:
- Multicycle MIPS main control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Supports R-format, lw, sw, beq, bne (optional), addi and j.
- Adds a memory-ready handshake, illegal-opcode flagging and a retired-instruction counter.
- Drives the multicycle datapath muxes and write enables.

Parameters:
ALUOP_W, 2, ALUOp width (>=2); bits above [1:0] driven 0
BNE_EN, 1, 1 = bne (6'b000101) supported; 0 = bne treated as illegal
CNT_W, 32, instr_count width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
opCode  in  6  instruction[31:26] from instruction register; sampled only in DECODE
mem_ready  in  1  memory completes current access this cycle
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
PCWrite  out  1  unconditional PC write
Branch  out  1  PC write if ALU zero
BranchNe  out  1  PC write if ALU not zero
PCSrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
ALUSrcA  out  1  0 = PC, 1 = rs register
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = MDR, 0 = ALUOut
RegWrite  out  1  register file write
ALUOp  out  ALUOP_W  00 = add, 01 = sub, 10 = funct-decoded
illegal_op  out  1  one-cycle pulse for an unsupported opcode
state  out  4  current state encoding (debug)
instr_count  out  CNT_W  retired instructions; wraps at 2^CNT_W

Behaviour:

Outputs and reset:
- Moore outputs from the state register. Every output not listed for a state is 0.
- reset high: next edge sets state = FETCH (0), instr_count = 0, illegal_op = 0.
- While reset is high, all strobes (MemRead, MemWrite, IRWrite, PCWrite, Branch, BranchNe, RegWrite) are forced to 0 combinationally.
- reset mid-instruction aborts the instruction with no count increment.

States (encoding) and outputs:
- FETCH(0): MemRead=1, ALUSrcB=01. IRWrite=PCWrite=mem_ready. Stay until mem_ready, then DECODE.
- DECODE(1): ALUSrcB=11. Next state by opCode:
  - 000000 -> RTYPEEX
  - 100011 / 101011 -> MEMADR
  - 000100 -> BEQEX
  - 000101 -> BNEEX if BNE_EN, else illegal
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - any other opcode: illegal_op=1 registered for exactly one cycle, next state FETCH, no count increment.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10. Next MEMRD for lw, MEMWR for sw (opCode still stable in IR).
- MEMRD(3): IorD=1, MemRead=1. Hold until mem_ready, then MEMWB.
- MEMWB(4): MemtoReg=1, RegWrite=1, RegDst=0. Next FETCH, retire.
- MEMWR(5): IorD=1, MemWrite=1, held every cycle until mem_ready. Then FETCH, retire.
- RTYPEEX(6): ALUSrcA=1, ALUOp=10. Next RTYPEWB.
- RTYPEWB(7): RegDst=1, RegWrite=1. Next FETCH, retire.
- BEQEX(8): ALUSrcA=1, ALUOp=01, PCSrc=01, Branch=1. Next FETCH, retire.
- ADDIEX(9): ALUSrcA=1, ALUSrcB=10. Next ADDIWB.
- ADDIWB(10): RegWrite=1. Next FETCH, retire.
- JEX(11): PCSrc=10, PCWrite=1. Next FETCH, retire.
- BNEEX(12): as BEQEX but BranchNe=1, Branch=0. Next FETCH, retire.
- Unused encodings 13-15: next state FETCH, outputs 0.

Retire and latency:
- Retire = instr_count increments by 1 on the transition edge into FETCH.
- Latency with mem_ready held 1 (cycles FETCH -> back to FETCH): lw 5; sw, R-format, addi 4; beq, bne, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds 1.
- mem_ready is ignored in all other states.

Test Plan:
- reset=1 for 2 cycles with mem_ready=1 -> all strobes 0 during reset; state=0 and instr_count=0 after.
- lw (100011) with mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 with MemtoReg=1 only in state 4; instr_count=1.
- sw (101011) with mem_ready low 3 cycles in MEMWR -> MemWrite=1 and IorD=1 for 4 consecutive cycles; then FETCH; RegWrite never 1.
- R-format, beq, addi, j back-to-back with mem_ready=1 -> 4+3+4+3 = 14 cycles; instr_count=4; ALUOp=10 in state 6, ALUOp=01 in state 8; PCWrite=1 with PCSrc=10 in state 11.
- opCode 6'b111111, and bne with BNE_EN=0 -> illegal_op one-cycle pulse after DECODE; return to FETCH; instr_count unchanged. bne with BNE_EN=1 -> state 12, BranchNe=1.
- reset asserted in MEMRD while mem_ready=0 -> state 0 next cycle; MemRead drops immediately; instr_count=0.
